fifo_fwft_adapter: RTL



---
 rtl/fifo_fwft_adapter_if.sv | 40 ++++
 rtl/fifo_fwft_adapter.sv | 107 ++++++++++
 2 files changed

// File: rtl/fifo_fwft_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fwft_adapter_if
// Description : FIFO read port and valid/ready stream bundle for the FWFT adapter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_fwft_adapter_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  fifo_empty_i;
    logic                  fifo_rd_en_o;
    logic [DATA_WIDTH-1:0] fifo_dout_i;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic [1:0]            level_o;

    // Adapter side
    modport master (
        input  fifo_empty_i,
        input  fifo_dout_i,
        input  m_ready_i,
        output fifo_rd_en_o,
        output m_valid_o,
        output m_data_o,
        output level_o
    );

    // FIFO / consumer side
    modport slave (
        output fifo_empty_i,
        output fifo_dout_i,
        output m_ready_i,
        input  fifo_rd_en_o,
        input  m_valid_o,
        input  m_data_o,
        input  level_o
    );
endinterface
`default_nettype wire

// File: rtl/fifo_fwft_adapter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fwft_adapter
// Description : Standard-read FIFO to first-word-fall-through stream, two-entry
//               head/skid buffer. Define FWFT_LEVEL_EN for a registered level_o.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_fwft_adapter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                       sys_clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    fifo_fwft_adapter_if.master        bus
);

    logic                  r_head_vld;
    logic                  r_skid_vld;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_head_dat;
    logic [DATA_WIDTH-1:0] r_skid_dat;

    logic                  w_head_vld_nxt;
    logic                  w_skid_vld_nxt;
    logic                  w_inflight_nxt;
    logic [DATA_WIDTH-1:0] w_head_dat_nxt;
    logic [DATA_WIDTH-1:0] w_skid_dat_nxt;

    logic [1:0]            w_cnt;
    logic [1:0]            w_occ;
    logic                  w_pop;
    logic                  w_rd_en;

    assign w_cnt   = {1'b0, r_head_vld} + {1'b0, r_skid_vld};
    assign w_occ   = w_cnt + {1'b0, r_inflight};
    assign w_pop   = r_head_vld & bus.m_ready_i;
    // Reset gates the request so it falls without waiting for a clock edge.
    assign w_rd_en = rst_n_i & ~bus.fifo_empty_i & ~flush_i &
                     ((w_occ < 2'd2) | w_pop);

    assign bus.fifo_rd_en_o = w_rd_en;
    assign bus.m_valid_o    = r_head_vld;
    assign bus.m_data_o     = r_head_dat;

    always_comb begin
        w_head_vld_nxt = r_head_vld;
        w_skid_vld_nxt = r_skid_vld;
        w_head_dat_nxt = r_head_dat;
        w_skid_dat_nxt = r_skid_dat;
        w_inflight_nxt = w_rd_en;
        if (flush_i) begin
            w_head_vld_nxt = 1'b0;
            w_skid_vld_nxt = 1'b0;
            w_inflight_nxt = 1'b0;
        end else begin
            if (w_pop) begin
                w_head_vld_nxt = r_skid_vld;
                w_head_dat_nxt = r_skid_vld ? r_skid_dat : r_head_dat;
                w_skid_vld_nxt = 1'b0;
            end
            // Arriving word lands behind whatever remains after the pop.
            if (r_inflight) begin
                if (!w_head_vld_nxt) begin
                    w_head_vld_nxt = 1'b1;
                    w_head_dat_nxt = bus.fifo_dout_i;
                end else begin
                    w_skid_vld_nxt = 1'b1;
                    w_skid_dat_nxt = bus.fifo_dout_i;
                end
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_inflight <= 1'b0;
            r_head_dat <= '0;
            r_skid_dat <= '0;
        end else begin
            r_head_vld <= w_head_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_inflight <= w_inflight_nxt;
            r_head_dat <= w_head_dat_nxt;
            r_skid_dat <= w_skid_dat_nxt;
        end
    end

`ifdef FWFT_LEVEL_EN
    logic [1:0] r_level;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_level <= 2'd0;
        end else begin
            r_level <= {1'b0, w_head_vld_nxt} + {1'b0, w_skid_vld_nxt};
        end
    end

    assign bus.level_o = r_level;
`else
    assign bus.level_o = 2'd0;
`endif

endmodule
`default_nettype wire
